// File: rtl/bcd_chain_counter.sv
// Multi-digit up/down counter chain with per-digit runtime maximum, parallel load,
// chain wrap pulse and zero detect. Define BCD_CHAIN_SATURATE_EN to saturate countdowns at zero.
module bcd_chain_counter #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    down,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_value,
  input  logic [DIGITS*WIDTH-1:0] max,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic [DIGITS-1:0]       digit_carry,
  output logic                    carry_out,
  output logic                    zero
);

  logic [DIGITS*WIDTH-1:0] r_count;
  logic [DIGITS-1:0]       r_digit_carry;
  logic                    r_carry_out;
  logic                    r_zero;

  logic [DIGITS*WIDTH-1:0] w_clamp;
  logic [DIGITS*WIDTH-1:0] w_next;
  logic [DIGITS-1:0]       w_step;
  logic [DIGITS-1:0]       w_wrap;
  logic                    w_ripple;
  logic                    w_carry_out;
  logic [WIDTH-1:0]        w_dig;
  logic [WIDTH-1:0]        w_max;

  for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
    assign w_clamp[g*WIDTH +: WIDTH] =
      (load_value[g*WIDTH +: WIDTH] > max[g*WIDTH +: WIDTH]) ?
      max[g*WIDTH +: WIDTH] : load_value[g*WIDTH +: WIDTH];
  end

`ifdef BCD_CHAIN_SATURATE_EN
  // Armed when the count reached zero by stepping; the next saturated step consumes it.
  logic r_armed;
  logic w_armed_next;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_next      = r_count;
    w_step      = '0;
    w_wrap      = '0;
    w_dig       = '0;
    w_max       = '0;
    w_ripple    = en;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig     = r_count[i*WIDTH +: WIDTH];
      w_max     = max[i*WIDTH +: WIDTH];
      w_step[i] = w_ripple;
      if (w_ripple) begin
        if (!down) begin
          if (w_dig >= w_max) begin
            w_next[i*WIDTH +: WIDTH] = '0;
            w_wrap[i]                = 1'b1;
          end else begin
            w_next[i*WIDTH +: WIDTH] = w_dig + WIDTH'(1);
          end
        end else if (w_dig == '0) begin
          w_next[i*WIDTH +: WIDTH] = w_max;
          w_wrap[i]                = 1'b1;
        end else if (w_dig > w_max) begin
          w_next[i*WIDTH +: WIDTH] = w_max;
        end else begin
          w_next[i*WIDTH +: WIDTH] = w_dig - WIDTH'(1);
        end
      end
      w_ripple = w_wrap[i];
    end
    w_carry_out = w_wrap[DIGITS-1];
`ifdef BCD_CHAIN_SATURATE_EN
    w_armed_next = (w_next == '0);
    if (en && down && (r_count == '0)) begin
      w_next       = r_count;
      w_wrap       = '0;
      w_carry_out  = r_armed;
      w_armed_next = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count       <= '0;
      r_digit_carry <= '0;
      r_carry_out   <= 1'b0;
      r_zero        <= 1'b1;
    end else if (load) begin
      r_count       <= w_clamp;
      r_digit_carry <= '0;
      r_carry_out   <= 1'b0;
      r_zero        <= (w_clamp == '0);
    end else if (en) begin
      r_count       <= w_next;
      r_digit_carry <= w_wrap;
      r_carry_out   <= w_carry_out;
      r_zero        <= (w_next == '0);
    end else begin
      r_digit_carry <= '0;
      r_carry_out   <= 1'b0;
    end
  end

`ifdef BCD_CHAIN_SATURATE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_armed <= 1'b0;
    else if (load) r_armed <= 1'b0;
    else if (en)   r_armed <= w_armed_next;
  end
`endif

  assign count       = r_count;
  assign digit_carry = r_digit_carry;
  assign carry_out   = r_carry_out;
  assign zero        = r_zero;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed self-checking bench for bcd_chain_counter, DIGITS=2, WIDTH=4, max = 59.
module tb_bcd_chain_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       down;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] max;
  logic [7:0] count;
  logic [1:0] digit_carry;
  logic       carry_out;
  logic       zero;

  int checks   = 0;
  int failures = 0;

  bcd_chain_counter #(.DIGITS(2), .WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .down        (down),
    .load        (load),
    .load_value  (load_value),
    .max         (max),
    .count       (count),
    .digit_carry (digit_carry),
    .carry_out   (carry_out),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] c, input logic [1:0] dc,
                            input logic co, input logic z);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".dcarry"}, 32'(digit_carry), 32'(dc));
    check({tag, ".cout"}, 32'(carry_out), 32'(co));
    check({tag, ".zero"}, 32'(zero), 32'(z));
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; en = 1'b0; load_value = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; down = 1'b0; load = 1'b0;
    load_value = '0; max = 8'h59;
    #12;
    expect_all("reset", 8'h00, 2'b00, 1'b0, 1'b1);
    tick();
    rst = 1'b1;

    // Asynchronous reset mid-count
    do_load(8'h37);
    expect_all("load37", 8'h37, 2'b00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_all("async_rst", 8'h00, 2'b00, 1'b0, 1'b1);
    rst = 1'b1;

    // Up rollover 58 -> 59 -> 00
    do_load(8'h58);
    en = 1'b1; down = 1'b0;
    tick();
    expect_all("up59", 8'h59, 2'b00, 1'b0, 1'b0);
    tick();
    expect_all("up00", 8'h00, 2'b11, 1'b1, 1'b1);
    en = 1'b0;
    tick();
    expect_all("up_hold", 8'h00, 2'b00, 1'b0, 1'b1);

    // Down from 01
    do_load(8'h01);
    en = 1'b1; down = 1'b1;
    tick();
    expect_all("dn00", 8'h00, 2'b00, 1'b0, 1'b1);
`ifdef BCD_CHAIN_SATURATE_EN
    tick();
    expect_all("sat1", 8'h00, 2'b00, 1'b1, 1'b1);
    tick();
    expect_all("sat2", 8'h00, 2'b00, 1'b0, 1'b1);
`else
    tick();
    expect_all("dn59", 8'h59, 2'b11, 1'b1, 1'b0);
`endif
    en = 1'b0;
    tick();
    check("dn_idle.cout", 32'(carry_out), 32'd0);

    // Load clamp with priority over en
    load = 1'b1; en = 1'b1; down = 1'b0; load_value = 8'h7C;
    tick();
    expect_all("clamp", 8'h59, 2'b00, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    expect_all("clamp_step", 8'h00, 2'b11, 1'b1, 1'b1);
    en = 1'b0;

    // Mid-chain carry 09 -> 10
    do_load(8'h09);
    en = 1'b1;
    tick();
    expect_all("carry10", 8'h10, 2'b01, 1'b0, 1'b0);
    en = 1'b0;

    // Runtime max change: digit 0 above new max wraps on up step
    do_load(8'h08);
    max = 8'h55; en = 1'b1; down = 1'b0;
    tick();
    expect_all("max_up", 8'h10, 2'b01, 1'b0, 1'b0);
    en = 1'b0;

    // Down step with digit above max clamps to max without wrap
    max = 8'h59;
    do_load(8'h08);
    max = 8'h55; en = 1'b1; down = 1'b1;
    tick();
    expect_all("max_dn", 8'h05, 2'b00, 1'b0, 1'b0);

    // Hold with en low
    en = 1'b0;
    tick();
    expect_all("hold", 8'h05, 2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit up/down counter chain: the successor to the single-digit stopwatch counter. It replaces hand-wired cascades of digit counters in the stopwatch datapath (seconds, minutes, hundredths). Each digit has a runtime maximum, and the chain ripples carries internally within one clock. The block also supports synchronous parallel load, a chain-level wrap pulse and zero detect. Optional saturation stops countdowns at zero.

## Interface
Parameters:
- DIGITS, 4, number of cascaded digits (1..8); digit 0 is least significant
- WIDTH, 4, bits per digit (2..8)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  count tick; one step per cycle while high
- down  in  1  direction; 0 = up, 1 = down
- load  in  1  synchronous parallel load; has priority over en
- load_value  in  DIGITS*WIDTH  packed load data; digit i at [i*WIDTH +: WIDTH]
- max  in  DIGITS*WIDTH  packed per-digit maximum, same packing
- count  out  DIGITS*WIDTH  packed registered digit values
- digit_carry  out  DIGITS  registered; bit i = digit i wrapped on the last step
- carry_out  out  1  registered; one-cycle pulse when the whole chain wrapped
- zero  out  1  registered; 1 when all digits are 0

## Operation
- Reset (rst low, asynchronous): count = 0, digit_carry = 0, carry_out = 0, zero = 1. Outputs hold these values until the first rising clk with rst high.
- Priority per cycle: load > en > hold.
- **load = 1**
  - Each digit takes min(load_value digit, max digit).
  - digit_carry = 0, carry_out = 0.
  - zero is recomputed from the loaded value.
- **en = 1, load = 0:** digit i steps when i = 0 or digit i-1 wraps this cycle. The carry ripple is combinational within the cycle.
- **Up step:**
  - If digit >= max_i: digit := 0 and the digit wraps.
  - Otherwise: digit := digit + 1.
- **Down step:**
  - If digit == 0: digit := max_i and the digit wraps.
  - If digit > max_i: digit := max_i with no wrap.
  - Otherwise: digit := digit - 1.
- A digit with max_i = 0 stays at 0 and wraps on every step it takes.
- digit_carry[i] is 1 for exactly the cycle after a step in which digit i wrapped; otherwise 0.
- carry_out = digit_carry[DIGITS-1] registered, i.e. the full chain rolled over:
  - up: all digits were at max
  - down: all digits were 0
- **en = 0, load = 0:** count holds; digit_carry = 0, carry_out = 0.
- zero always reflects the registered count.
- down may change on any cycle. It takes effect on that cycle's step, with no pipeline.
- max may change on any cycle. The out-of-range rules above define behaviour; no illegal state exists.
- All arithmetic is unsigned, WIDTH bits. Wrap-around is handled only by the compare rules above, never by natural overflow.

## Timing
- Latency: one cycle from a sampled en/load to updated count, digit_carry, carry_out and zero.
- carry_out asserts in the same cycle the wrapped count first appears on count.
- Sustained en gives one step per clock.
- No handshake; en is a level-sampled tick from the prescaler.
- Reset mid-count: outputs clear immediately (asynchronous). Any step in flight is discarded.
- Deassertion of rst is synchronised externally.

## Configuration
- Macro: BCD_CHAIN_SATURATE_EN.
- **Defined:**
  - In down mode, an en step while all digits are 0 leaves count at 0. No digit_carry or carry_out is produced.
  - Instead, the chain-level terminal condition raises carry_out for one cycle, and only on the first such step after count became 0 by stepping.
  - Up mode is unchanged (wraps).
- **Undefined:** down mode wraps 00..0 to the max value on every digit, with carry_out, exactly as described in Operation.

## Test plan
Configuration for all scenarios unless stated: DIGITS = 2, WIDTH = 4, max = {5,9} (00..59).

- **Async reset:** drive count to 37, pull rst low between clock edges -> count = 00, zero = 1 and carries = 0 before the next edge.
- **Up rollover:** load 58, then en for 2 cycles up -> 59 then 00.
  - Second step: digit_carry = 2'b11, carry_out = 1 for exactly one cycle.
  - zero = 1.
- **Down wrap, macro undefined:** load 01, then en down for 2 cycles -> 00 then 59, carry_out = 1 on the 59 cycle.
- **Saturation, macro defined:** load 01, then en down for 3 cycles -> 00, 00, 00.
  - carry_out pulses once, on the first 00 hold.
- **Load clamp and priority:** load = 1 and en = 1 with load_value = {7,12} -> count = 59 (clamped) and no step.
  - Next, en up -> 00 with carry_out = 1.
- **Runtime max change:** at count 08, change max digit 0 to 5, then step up -> digit 0 wraps to 0 and digit 1 increments, giving 10.
